// File: rtl/logic_unit_pipe_if.sv
// Bus bundle for the pipelined logic unit: operand/op request channel and
// result/flag response channel, each with its own valid/ready pair.
interface logic_unit_pipe_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] inp1;
   logic [WIDTH-1:0] inp2;
   logic [2:0]       op;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out;
   logic             out_zero;
   logic             out_ones;
   logic             out_parity;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output inp1, inp2, op, in_valid, out_ready,
      input  in_ready, out, out_zero, out_ones, out_parity, out_valid
   );

   modport slave (
      input  inp1, inp2, op, in_valid, out_ready,
      output in_ready, out, out_zero, out_ones, out_parity, out_valid
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit: S1 captures operands and op,
// S2 holds the result with zero/all-ones/parity flags.
module logic_unit_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   logic_unit_pipe_if.slave lu
);

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       op_q;
   logic             s1_valid_q;

   logic [WIDTH-1:0] res_q;
   logic             zero_q;
   logic             ones_q;
   logic             par_q;
   logic             s2_valid_q;

   logic [WIDTH-1:0] res_d;
   logic             zero_d;
   logic             ones_d;
   logic             par_d;
   logic             s1_adv;
   logic             s2_adv;

   function automatic logic [WIDTH-1:0] calc(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic [2:0]       sel);
      logic [WIDTH-1:0] r;
      case (sel)
         3'b000:  r = x & y;
         3'b001:  r = x | y;
         3'b010:  r = x ^ y;
         3'b011:  r = ~(x & y);
         3'b100:  r = ~(x | y);
         3'b101:  r = ~(x ^ y);
         3'b110:  r = ~x;
         3'b111:  r = x & ~y;
         default: r = x & y;
      endcase
      return r;
   endfunction

   function automatic logic parity(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   // in_ready is gated by reset so nothing is accepted while the pipe is being cleared
   assign s2_adv      = ~s2_valid_q | lu.out_ready;
   assign s1_adv      = ~s1_valid_q | s2_adv;
   assign lu.in_ready = rst & s1_adv;

   always_comb begin
      res_d  = calc(a_q, b_q, op_q);
      zero_d = (res_d == '0);
      ones_d = (res_d == '1);
      par_d  = parity(res_d);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= 3'b000;
      end else if (s1_adv) begin
         s1_valid_q <= lu.in_valid;
         if (lu.in_valid) begin
            a_q  <= lu.inp1;
            b_q  <= lu.inp2;
            op_q <= lu.op;
         end
      end
   end

   // S2 keeps its last result when emptied so a stalled output never glitches
   always_ff @(posedge clk) begin
      if (!rst) begin
         s2_valid_q <= 1'b0;
         res_q      <= '0;
         zero_q     <= 1'b0;
         ones_q     <= 1'b0;
         par_q      <= 1'b0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            res_q  <= res_d;
            zero_q <= zero_d;
            ones_q <= ones_d;
            par_q  <= par_d;
         end
      end
   end

   assign lu.out        = res_q;
   assign lu.out_zero   = zero_q;
   assign lu.out_ones   = ones_q;
   assign lu.out_parity = par_q;
   assign lu.out_valid  = s2_valid_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Lockstep bench for 8/16/32-bit logic_unit_pipe instances sharing one
// handshake stream, checked against a queue-based truth-table model.
module tb_logic_unit_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic [2:0]  op;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic [2:0]  op;
   } xfer_t;

   xfer_t sb_q[$];

   logic        stall_prev = 1'b0;
   logic [18:0] held16 = '0;
   logic [31:0] held32 = '0;

   logic_unit_pipe_if #(.WIDTH(8))  bus8 ();
   logic_unit_pipe_if #(.WIDTH(16)) bus16 ();
   logic_unit_pipe_if #(.WIDTH(32)) bus32 ();

   assign bus8.inp1      = a[7:0];
   assign bus8.inp2      = b[7:0];
   assign bus8.op        = op;
   assign bus8.in_valid  = in_valid;
   assign bus8.out_ready = out_ready;
   assign bus16.inp1      = a[15:0];
   assign bus16.inp2      = b[15:0];
   assign bus16.op        = op;
   assign bus16.in_valid  = in_valid;
   assign bus16.out_ready = out_ready;
   assign bus32.inp1      = a[31:0];
   assign bus32.inp2      = b[31:0];
   assign bus32.op        = op;
   assign bus32.in_valid  = in_valid;
   assign bus32.out_ready = out_ready;

   logic_unit_pipe #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .lu(bus8.slave));
   logic_unit_pipe #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .lu(bus16.slave));
   logic_unit_pipe #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .lu(bus32.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Truth table of the eight operations, evaluated at full 64-bit width
   function automatic logic [63:0] ref_res(input xfer_t x);
      case (x.op)
         3'd0:    return x.a & x.b;
         3'd1:    return x.a | x.b;
         3'd2:    return x.a ^ x.b;
         3'd3:    return ~(x.a & x.b);
         3'd4:    return ~(x.a | x.b);
         3'd5:    return ~(x.a ^ x.b);
         3'd6:    return ~x.a;
         default: return x.a & ~x.b;
      endcase
   endfunction

   task automatic check_lane(input string w, input logic [63:0] got, input logic z,
                             input logic o, input logic p, input int width,
                             input logic [63:0] r);
      logic [63:0] mask;
      logic [63:0] m;
      mask = (64'd1 << width) - 64'd1;
      m    = r & mask;
      chk({"out", w},  got, m);
      chk({"zero", w}, {63'd0, z}, {63'd0, (m == 64'd0)});
      chk({"ones", w}, {63'd0, o}, {63'd0, (m == mask)});
      chk({"par", w},  {63'd0, p}, 64'($countones(m) % 2));
   endtask

   task automatic monitor_step();
      xfer_t       x;
      logic [63:0] r;
      if (stall_prev) begin
         chk("hold16", {45'd0, bus16.out, bus16.out_zero, bus16.out_ones, bus16.out_parity},
             {45'd0, held16});
         chk("hold32", {32'd0, bus32.out}, {32'd0, held32});
      end
      if (bus16.out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
         end else begin
            x = sb_q.pop_front();
            r = ref_res(x);
            check_lane("8",  {56'd0, bus8.out},  bus8.out_zero,  bus8.out_ones,  bus8.out_parity,  8,  r);
            check_lane("16", {48'd0, bus16.out}, bus16.out_zero, bus16.out_ones, bus16.out_parity, 16, r);
            check_lane("32", {32'd0, bus32.out}, bus32.out_zero, bus32.out_ones, bus32.out_parity, 32, r);
         end
      end
      if (in_valid && bus16.in_ready) begin
         x.a  = a;
         x.b  = b;
         x.op = op;
         sb_q.push_back(x);
      end
      stall_prev = rst && bus16.out_valid && !out_ready;
      held16     = {bus16.out, bus16.out_zero, bus16.out_ones, bus16.out_parity};
      held32     = bus32.out;
      if (!rst) sb_q.delete();
   endtask

   // Scoreboard runs mid-cycle, when handshakes for the coming edge are settled
   always @(negedge clk) monitor_step();

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] sweep_exp [8];
   int          acc;
   int          n_acc;
   logic [15:0] first_out;

   initial begin
      sweep_exp = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0FF0, 16'hF00F};
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = 64'd0; b = 64'd0; op = 3'd0;

      // Reset, then a single AND
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {63'd0, bus16.out_valid}, 64'd0);
      chk("rst_ready", {63'd0, bus16.in_ready}, 64'd0);
      chk("rst_out",   {48'd0, bus16.out}, 64'd0);
      chk("rst_flags", {61'd0, bus16.out_zero, bus16.out_ones, bus16.out_parity}, 64'd0);
      drive_edge();
      rst = 1'b1; in_valid = 1'b1; a = 64'h000B; b = 64'h000D; op = 3'd0;
      @(negedge clk);
      chk("t1_ready", {63'd0, bus16.in_ready}, 64'd1);
      drive_edge();
      in_valid = 1'b0;
      @(negedge clk);
      chk("t1_lat_v0", {63'd0, bus16.out_valid}, 64'd0);
      drive_edge();
      @(negedge clk);
      chk("t1_lat_v1", {63'd0, bus16.out_valid}, 64'd1);
      chk("t1_out",    {48'd0, bus16.out}, 64'h0009);
      chk("t1_flags",  {61'd0, bus16.out_zero, bus16.out_ones, bus16.out_parity}, 64'd0);

      // Op sweep streamed back-to-back
      drive_edge();
      for (int k = 0; k < 10; k++) begin
         in_valid = (k < 8);
         a = 64'hF00F; b = 64'h0FF0; op = 3'(k);
         @(negedge clk);
         if (k < 8) chk("sweep_ready", {63'd0, bus16.in_ready}, 64'd1);
         if (k >= 2) begin
            chk("sweep_valid", {63'd0, bus16.out_valid}, 64'd1);
            chk("sweep_out", {48'd0, bus16.out}, {48'd0, sweep_exp[k-2]});
         end
         drive_edge();
      end

      // Backpressure: only two vectors fit while the output is stalled
      out_ready = 1'b0; acc = 0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 3'($urandom_range(0, 7));
         @(negedge clk);
         if (bus16.in_ready) acc++;
         drive_edge();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_accepts", 64'(acc), 64'd2);
      chk("bp_ready",   {63'd0, bus16.in_ready}, 64'd0);
      chk("bp_valid",   {63'd0, bus16.out_valid}, 64'd1);
      first_out = bus16.out;
      drive_edge();
      out_ready = 1'b1; in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 3'd7;
      @(negedge clk);
      chk("bp_first_held", {48'd0, bus16.out}, {48'd0, first_out});
      chk("simul_ready",   {63'd0, bus16.in_ready}, 64'd1);
      if (bus16.in_ready) acc++;
      for (int c = 0; c < 10 && acc < 4; c++) begin
         drive_edge();
         a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 3'($urandom_range(0, 7));
         @(negedge clk);
         if (bus16.in_ready) acc++;
      end
      chk("bp_total", 64'(acc), 64'd4);
      drive_edge();
      in_valid = 1'b0;
      repeat (4) drive_edge();

      // Reset with two results in flight
      out_ready = 1'b0; in_valid = 1'b1;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 3'd2;
      drive_edge();
      a = {$urandom, $urandom}; op = 3'd5;
      drive_edge();
      in_valid = 1'b0; rst = 1'b0;
      drive_edge();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", {63'd0, bus16.out_valid}, 64'd0);
      chk("mid_rst_out",   {48'd0, bus16.out}, 64'd0);
      drive_edge();
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("mid_rst_quiet", {63'd0, bus16.out_valid}, 64'd0);
         drive_edge();
      end

      // Width-specific boundaries
      in_valid = 1'b1; a = 64'h8000_0080; b = 64'h0100_0001; op = 3'd1;
      drive_edge();
      a = 64'd0; b = {$urandom, $urandom}; op = 3'd6;
      drive_edge();
      in_valid = 1'b0;
      @(negedge clk);
      chk("w8_or",   {56'd0, bus8.out}, 64'h81);
      chk("w8_par",  {63'd0, bus8.out_parity}, 64'd0);
      chk("w32_or",  {32'd0, bus32.out}, 64'h8100_0081);
      chk("w32_par", {63'd0, bus32.out_parity}, 64'd0);
      drive_edge();
      @(negedge clk);
      chk("w8_not",   {56'd0, bus8.out}, 64'hFF);
      chk("w8_ones",  {63'd0, bus8.out_ones}, 64'd1);
      chk("w32_not",  {32'd0, bus32.out}, 64'hFFFF_FFFF);
      chk("w32_ones", {63'd0, bus32.out_ones}, 64'd1);
      drive_edge();

      // Random traffic with random backpressure
      n_acc = 0;
      for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 1) != 0);
         a  = ($urandom_range(0, 15) == 0) ? 64'd0 : {$urandom, $urandom};
         b  = ($urandom_range(0, 15) == 0) ? '1 : {$urandom, $urandom};
         op = 3'($urandom_range(0, 7));
         @(negedge clk);
         if (in_valid && bus16.in_ready) n_acc++;
         drive_edge();
      end
      chk("rand_transfers", 64'(n_acc), 64'd1000);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 10 && sb_q.size() != 0; c++) drive_edge();
      @(negedge clk);
      chk("drain_empty", 64'(sb_q.size()), 64'd0);
      chk("drain_valid", {63'd0, bus16.out_valid}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit for the ALU logical-operations group.
- Generalises the registered 16-bit AND to WIDTH bits and eight selectable operations.
- Adds two-stage valid/ready pipelining with backpressure and result flags.
- Sits between the ALU operand mux and the ALU result arbiter.

Parameters:
WIDTH, 16, operand/result width in bits (legal range 2 to 64)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous active-low reset (sampled on rising edge of clk)
inp1  input  WIDTH  operand A
inp2  input  WIDTH  operand B
op  input  3  operation select, captured with the operands
in_valid  input  1  upstream offers inp1/inp2/op
in_ready  output  1  block accepts this cycle
out  output  WIDTH  result
out_zero  output  1  result == 0
out_ones  output  1  result == all ones
out_parity  output  1  XOR-reduction of result
out_valid  output  1  out and flags are valid
out_ready  input  1  downstream accepts this cycle

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Reset is sampled only on rising clk edges; there is no asynchronous reset path.
- Reset (rst=0 at an edge): S1 and S2 valid bits are cleared. out, out_zero, out_ones and out_parity go to 0. out_valid goes to 0.
- During reset, in_ready is 0 (combinationally gated by rst). Any in-flight data is discarded; there is no flush handshake.
- op encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NAND
  - 100 NOR
  - 101 XNOR
  - 110 NOT inp1 (inp2 ignored)
  - 111 ANDN = inp1 & ~inp2
  - All codes are legal.
- Stage S1 registers inp1, inp2, op and s1_valid.
- Stage S2 registers the computed result, the three flags and s2_valid. out_valid = s2_valid.
- Advance rules:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = rst & s1_adv
- An input transfer occurs when in_valid & in_ready at an edge.
- The output transfer occurs on out_valid & out_ready.
- Latency: a transfer at edge E loads S1 at E and S2 at E+1. out_valid is high from E+1 until consumed. Throughput is one result per cycle when out_ready stays high.
- When S1 loads with no new transfer, s1_valid clears. When S2 advances with s1_valid=0, s2_valid clears.
- Stall: while out_valid & !out_ready, out and the flags hold stable bit-for-bit. S1 may still fill once; in_ready then drops. No data is lost or duplicated.
- Simultaneous consume and accept in a full pipe: S2 takes S1, S1 takes the new input in the same edge.
- Flags are computed from the S2 result, never from the inputs.
- For WIDTH=16: result 0x0000 gives zero=1, ones=0, parity=0; result 0xFFFF gives ones=1, parity=0.
- inp1, inp2 and op may change freely while in_valid=0 or in_ready=0. Only transferred values affect results.
- Reset taking effect mid-stream drops both stages. The first new transfer after rst returns high behaves as from power-up.

Test Plan:
1. Reset then basic op (WIDTH=16): hold rst=0 for 2 edges, then op=000, inp1=0x000B, inp2=0x000D, out_ready=1 -> out_valid high one edge after acceptance with out=0x0009, zero=0, ones=0, parity=0. All outputs read 0 during reset.
2. Op sweep: inp1=0xF00F, inp2=0x0FF0, op=000..111 streamed back-to-back -> in order 0x0000(z=1), 0xFFFF(ones=1), 0xFFFF, 0xFFFF, 0x0000, 0x0000, 0x0FF0, 0xF00F. One result per cycle, no bubbles.
3. Backpressure: stream 4 vectors with out_ready=0 -> after 2 accepts in_ready=0 and out holds the first result unchanged. Release out_ready -> all 4 results emerge in order with no loss or duplication.
4. Simultaneous consume/accept: pipe full, out_ready=1 and in_valid=1 at the same edge -> S2 updates to the S1 value and S1 captures the new operands. Throughput is unchanged.
5. Reset mid-stream: 2 vectors in flight, assert rst=0 for one edge -> out_valid=0 and out=0 next cycle, and none of the in-flight results are ever emitted.
6. Width generalisation (WIDTH=8 and WIDTH=32): op=001, inp1=0x80.., inp2=0x01.. -> out=0x81.., parity=0. op=110 with inp1=0 -> all ones, ones=1. Results are checked against a reference model on 1000 random transfers with random out_ready.
